qm_out_sched: RTL and testbench



---
 rtl/qm_out_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_qm_out_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qm_out_sched.sv
// qm_out_sched: egress scheduler for NUM_Q queue managers sharing one port.
//
// Round-robin arbitration over queues that hold a complete frame (pointer
// FIFO not empty) and are enabled. The winner's length word is popped,
// then exactly that many bytes are read from its data FIFO. The bytes are
// re-emitted as a framed stream (sof/dv/eof). A frame, once granted, always
// runs to completion; IFG idle cycles follow each frame.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   q_en             per-queue eligibility, sampled in IDLE only
//   ptr_fifo_empty   per-queue pointer FIFO empty
//   ptr_fifo_rd      one-hot single-cycle pointer FIFO pop
//   ptr_fifo_dout    16 bits per queue, [11:0] = frame byte count
//   data_fifo_rd     one-hot data FIFO pop
//   data_fifo_dout   8 bits per queue
//   out_bp           egress backpressure, sampled in IDLE only
//   out_sof/eof/dv   frame markers and byte valid
//   out_data         frame byte
//   out_port         queue currently (or last) served
//   busy             high whenever the scheduler is not idle
//   zero_len         one-cycle pulse when a popped length word is 0

// Per-queue slice: request qualification and the one-hot read-back mux leg.
module qm_out_sched_lane (
    input  logic        empty,
    input  logic        en,
    input  logic        sel,
    input  logic [15:0] ptr_word,
    input  logic [7:0]  data_byte,
    output logic        req,
    output logic [11:0] len_sel,
    output logic [7:0]  byte_sel
);
    // Upper nibble of the length word carries nothing we use.
    logic unused_hi;
    assign unused_hi = ^ptr_word[15:12];

    assign req      = ~empty & en;
    assign len_sel  = sel ? ptr_word[11:0] : 12'd0;
    assign byte_sel = sel ? data_byte : 8'd0;
endmodule

module qm_out_sched #(
    parameter int NUM_Q = 4,
    parameter int QW    = 3,
    parameter int IFG   = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_Q-1:0]     q_en,
    input  logic [NUM_Q-1:0]     ptr_fifo_empty,
    output logic [NUM_Q-1:0]     ptr_fifo_rd,
    input  logic [16*NUM_Q-1:0]  ptr_fifo_dout,
    output logic [NUM_Q-1:0]     data_fifo_rd,
    input  logic [8*NUM_Q-1:0]   data_fifo_dout,
    input  logic                 out_bp,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 out_dv,
    output logic [7:0]           out_data,
    output logic [QW-1:0]        out_port,
    output logic                 busy,
    output logic                 zero_len
);
    // Gap counter holds IFG-1 down to 0.
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_LEN,
        S_DATA,
        S_TAIL,
        S_GAP
    } state_t;

    state_t                  state, state_n;
    logic [QW-1:0]           last_q;
    logic [QW-1:0]           grant;
    logic                    grant_vld;
    int                      rr_idx;
    logic [NUM_Q-1:0]        req;
    logic [NUM_Q-1:0]        sel;
    logic [NUM_Q-1:0][11:0]  lane_len;
    logic [NUM_Q-1:0][7:0]   lane_byte;
    logic [11:0]             len_in;
    logic [7:0]              byte_in;
    logic [11:0]             len_q;
    logic [11:0]             rem;
    logic                    tail_cnt;
    logic [GW-1:0]           gap_cnt;
    // vld_pipe[0] mirrors data_fifo_rd, [1] is FIFO dout valid, [2] is out_dv.
    logic [2:0]              vld_pipe;
    logic                    sof_tag, eof_tag;
    logic                    sof_d1, eof_d1;

    // Lanes: request qualification and a one-hot mux keyed by out_port,
    // which is stable for the whole frame.
    for (genvar i = 0; i < NUM_Q; i++) begin : g_lane
        assign sel[i] = (out_port == QW'(i));
        qm_out_sched_lane u_lane (
            .empty     (ptr_fifo_empty[i]),
            .en        (q_en[i]),
            .sel       (sel[i]),
            .ptr_word  (ptr_fifo_dout[16*i +: 16]),
            .data_byte (data_fifo_dout[8*i +: 8]),
            .req       (req[i]),
            .len_sel   (lane_len[i]),
            .byte_sel  (lane_byte[i])
        );
    end

    always_comb begin
        len_in  = '0;
        byte_in = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            len_in  = len_in | lane_len[i];
            byte_in = byte_in | lane_byte[i];
        end
    end

    // Round-robin search from last_q+1. Walking from the farthest candidate
    // to the nearest lets the nearest requester overwrite the others.
    always_comb begin
        grant     = last_q;
        grant_vld = 1'b0;
        rr_idx    = 0;
        for (int k = NUM_Q; k >= 1; k--) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= NUM_Q) rr_idx = rr_idx - NUM_Q;
            if (req[rr_idx]) begin
                grant     = QW'(rr_idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (!out_bp && grant_vld) state_n = S_PTR;
            S_PTR:  state_n = S_LEN;
            S_LEN: begin
                if (len_in == 12'd0) state_n = (IFG == 0) ? S_IDLE : S_GAP;
                else                 state_n = S_DATA;
            end
            S_DATA: if (rem == 12'd1) state_n = S_TAIL;
            // Two cycles let the last byte clear the FIFO and output stages.
            S_TAIL: if (tail_cnt) state_n = (IFG == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (gap_cnt == '0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign sof_tag = (state == S_DATA) && (rem == len_q);
    assign eof_tag = (state == S_DATA) && (rem == 12'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            last_q       <= QW'(NUM_Q - 1);
            out_port     <= '0;
            ptr_fifo_rd  <= '0;
            data_fifo_rd <= '0;
            len_q        <= '0;
            rem          <= '0;
            tail_cnt     <= 1'b0;
            gap_cnt      <= '0;
            zero_len     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state       <= state_n;
            busy        <= (state_n != S_IDLE);
            ptr_fifo_rd <= '0;
            zero_len    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_n == S_PTR) begin
                        out_port    <= grant;
                        ptr_fifo_rd <= NUM_Q'(1) << grant;
                    end
                end
                S_LEN: begin
                    len_q <= len_in;
                    rem   <= len_in;
                    if (len_in == 12'd0) begin
                        zero_len <= 1'b1;
                        last_q   <= out_port;
                        gap_cnt  <= GW'(IFG - 1);
                    end else begin
                        data_fifo_rd <= sel;
                    end
                end
                S_DATA: begin
                    rem <= rem - 12'd1;
                    if (rem == 12'd1) begin
                        data_fifo_rd <= '0;
                        tail_cnt     <= 1'b0;
                    end
                end
                S_TAIL: begin
                    tail_cnt <= 1'b1;
                    if (tail_cnt) begin
                        last_q  <= out_port;
                        gap_cnt <= GW'(IFG - 1);
                    end
                end
                S_GAP: gap_cnt <= gap_cnt - GW'(1);
                default: ;
            endcase
        end
    end

    // Output pipeline: FIFO read -> FIFO dout -> registered output byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            sof_d1   <= 1'b0;
            eof_d1   <= 1'b0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
            out_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], (state_n == S_DATA)};
            sof_d1   <= sof_tag;
            eof_d1   <= eof_tag;
            out_sof  <= sof_d1;
            out_eof  <= eof_d1;
            out_data <= vld_pipe[1] ? byte_in : 8'd0;
        end
    end

    assign out_dv = vld_pipe[2];
endmodule

// File: tb/tb_qm_out_sched.sv
// Directed bench for qm_out_sched: behavioural FIFO models per queue, a
// negedge monitor logging grants/bytes, and immediate-assertion checks.
module tb_qm_out_sched;
    localparam int NUM_Q = 4;
    localparam int QW    = 3;
    localparam int IFG   = 12;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NUM_Q-1:0]     q_en = '0;
    logic [NUM_Q-1:0]     ptr_fifo_empty;
    logic [NUM_Q-1:0]     ptr_fifo_rd;
    logic [16*NUM_Q-1:0]  ptr_fifo_dout;
    logic [NUM_Q-1:0]     data_fifo_rd;
    logic [8*NUM_Q-1:0]   data_fifo_dout;
    logic                 out_bp = 1'b0;
    logic                 out_sof, out_eof, out_dv;
    logic [7:0]           out_data;
    logic [QW-1:0]        out_port;
    logic                 busy, zero_len;

    qm_out_sched #(.NUM_Q(NUM_Q), .QW(QW), .IFG(IFG)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .q_en           (q_en),
        .ptr_fifo_empty (ptr_fifo_empty),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .out_bp         (out_bp),
        .out_sof        (out_sof),
        .out_eof        (out_eof),
        .out_dv         (out_dv),
        .out_data       (out_data),
        .out_port       (out_port),
        .busy           (busy),
        .zero_len       (zero_len)
    );

    always #5 clk = ~clk;

    // FIFO models: read in cycle T gives dout in cycle T+1.
    logic [15:0] pmem [NUM_Q][16];
    logic [7:0]  dmem [NUM_Q][256];
    int pwr [NUM_Q];
    int dwr [NUM_Q];
    int prd [NUM_Q];
    int drd [NUM_Q];

    always_comb begin
        ptr_fifo_empty = '0;
        for (int i = 0; i < NUM_Q; i++) ptr_fifo_empty[i] = (pwr[i] == prd[i]);
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_Q; i++) begin
                prd[i] <= 0;
                drd[i] <= 0;
            end
            ptr_fifo_dout  <= '0;
            data_fifo_dout <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (ptr_fifo_rd[i] && (pwr[i] != prd[i])) begin
                    ptr_fifo_dout[16*i +: 16] <= pmem[i][prd[i] % 16];
                    prd[i] <= prd[i] + 1;
                end
                if (data_fifo_rd[i]) begin
                    if (dwr[i] != drd[i]) begin
                        data_fifo_dout[8*i +: 8] <= dmem[i][drd[i] % 256];
                        drd[i] <= drd[i] + 1;
                    end else begin
                        data_fifo_dout[8*i +: 8] <= 8'hEE;
                    end
                end
            end
        end
    end

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ngnt = 0, ncap = 0, neof = 0, nzl = 0, viol = 0, zl_cyc = 0;
    int gnt_q [64];
    int gnt_cyc [64];
    int drd_cnt [NUM_Q];
    logic [7:0]    cap_data [512];
    logic          cap_sof  [512];
    logic          cap_eof  [512];
    logic [QW-1:0] cap_port [512];
    int            cap_cyc  [512];

    function automatic int oh2i(input logic [NUM_Q-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < NUM_Q; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (ptr_fifo_rd != '0 && ngnt < 64) begin
                gnt_q[ngnt]   <= oh2i(ptr_fifo_rd);
                gnt_cyc[ngnt] <= cyc;
                ngnt          <= ngnt + 1;
            end
            if (!$onehot0(ptr_fifo_rd) || !$onehot0(data_fifo_rd) ||
                ((|ptr_fifo_rd) && (|data_fifo_rd)))
                viol <= viol + 1;
            for (int i = 0; i < NUM_Q; i++)
                if (data_fifo_rd[i]) drd_cnt[i] <= drd_cnt[i] + 1;
            if (zero_len) begin
                nzl    <= nzl + 1;
                zl_cyc <= cyc;
            end
            if (out_eof) neof <= neof + 1;
            if (out_dv && ncap < 512) begin
                cap_data[ncap] <= out_data;
                cap_sof[ncap]  <= out_sof;
                cap_eof[ncap]  <= out_eof;
                cap_port[ncap] <= out_port;
                cap_cyc[ncap]  <= cyc;
                ncap           <= ncap + 1;
            end
        end
    end

    // Checking helpers
    int checks = 0, errors = 0;
    int g0, c0, e0, z0, d0, d1, d2, n;
    logic [31:0] ev;
    int ord_rr [6] = '{0, 2, 3, 0, 2, 3};
    int ord_z  [3] = '{0, 1, 2};
    int ord_m  [3] = '{0, 1, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int q, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            dmem[q][dwr[q] % 256] = base + 8'(k);
            dwr[q]++;
        end
        // Upper nibble set to junk: the scheduler must ignore it.
        pmem[q][pwr[q] % 16] = {4'hA, 12'(len)};
        pwr[q]++;
    endtask

    task automatic wait_eof(input int target, input int budget);
        int w;
        w = 0;
        while (neof < target && w < budget) begin
            tick(1);
            w++;
        end
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        out_bp = 1'b0;
        q_en   = '1;
        for (int i = 0; i < NUM_Q; i++) begin
            pwr[i] = 0;
            dwr[i] = 0;
        end
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic snap();
        g0 = ngnt; c0 = ncap; e0 = neof; z0 = nzl;
        d0 = drd_cnt[0]; d1 = drd_cnt[1]; d2 = drd_cnt[2];
    endtask

    initial begin
        for (int i = 0; i < NUM_Q; i++) begin
            pwr[i] = 0;
            dwr[i] = 0;
        end
        rstn = 1'b0;
        tick(3);

        // Reset state
        chk("rst_ctl", {27'd0, out_sof, out_eof, out_dv, busy, zero_len}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_port", {29'd0, out_port}, 32'd0);
        chk("rst_ptr_rd", {28'd0, ptr_fifo_rd}, 32'd0);
        chk("rst_data_rd", {28'd0, data_fifo_rd}, 32'd0);
        rstn = 1'b1;
        q_en = '1;
        tick(2);

        // Single frame on queue 1, len 5
        snap();
        push_frame(1, 5, 8'hA0);
        wait_eof(e0 + 1, 100);
        tick(3);
        chk("t1_eofs", neof - e0, 1);
        chk("t1_grants", ngnt - g0, 1);
        chk("t1_grant_q", gnt_q[g0], 1);
        chk("t1_data_rd", drd_cnt[1] - d1, 5);
        chk("t1_nbytes", ncap - c0, 5);
        for (int k = 0; k < 5; k++) begin
            ev = {19'd0, (k == 0), (k == 4), 3'd1, 8'(8'hA0 + k)};
            chk("t1_byte", {19'd0, cap_sof[c0+k], cap_eof[c0+k], cap_port[c0+k], cap_data[c0+k]}, ev);
        end
        // ptr_rd is one cycle after the IDLE decision; out_dv is 5 after it.
        chk("t1_latency", cap_cyc[c0] - gnt_cyc[g0], 4);

        // Round-robin over queues 0, 2, 3, two frames each
        do_reset();
        snap();
        for (int f = 0; f < 2; f++) begin
            push_frame(0, 3, 8'(f * 4));
            push_frame(2, 3, 8'(32 + f * 4));
            push_frame(3, 3, 8'(48 + f * 4));
        end
        wait_eof(e0 + 6, 600);
        tick(3);
        chk("t2_eofs", neof - e0, 6);
        chk("t2_grants", ngnt - g0, 6);
        for (int k = 0; k < 6; k++) chk("t2_order", gnt_q[g0+k], ord_rr[k]);
        chk("t2_q1_unread", drd_cnt[1] - d1, 0);
        chk("t2_nbytes", ncap - c0, 18);
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 3; j++) begin
                ev = {21'd0, 3'(ord_rr[k]), 8'(ord_rr[k] * 16 + (k / 3) * 4 + j)};
                chk("t2_byte", {21'd0, cap_port[c0+3*k+j], cap_data[c0+3*k+j]}, ev);
            end
        // eof -> IFG gap -> IDLE, PTR, LEN, DATA -> 2-cycle pipe = 18 cycles
        for (int k = 0; k < 5; k++)
            chk("t2_ifg", cap_cyc[c0+3*k+3] - cap_cyc[c0+3*k+2], 18);

        // Backpressure
        do_reset();
        snap();
        out_bp = 1'b1;
        push_frame(0, 4, 8'h40);
        push_frame(0, 4, 8'h50);
        tick(10);
        chk("t3_bp_grants", ngnt - g0, 0);
        chk("t3_bp_busy", {31'd0, busy}, 0);
        chk("t3_bp_ptr_rd", {28'd0, ptr_fifo_rd}, 0);
        out_bp = 1'b0;
        tick(1);
        chk("t3_release1", {28'd0, ptr_fifo_rd}, 32'b0001);
        tick(3);
        out_bp = 1'b1;
        wait_eof(e0 + 1, 100);
        tick(40);
        chk("t3_eofs", neof - e0, 1);
        chk("t3_nbytes", ncap - c0, 4);
        for (int k = 0; k < 4; k++) chk("t3_byte", {24'd0, cap_data[c0+k]}, 32'h40 + k);
        chk("t3_bp_hold2", ngnt - g0, 1);
        out_bp = 1'b0;
        tick(1);
        chk("t3_release2", {28'd0, ptr_fifo_rd}, 32'b0001);
        wait_eof(e0 + 2, 100);
        chk("t3_nbytes2", ncap - c0, 8);

        // len=1 then len=0, then grant advances
        do_reset();
        snap();
        push_frame(0, 1, 8'h55);
        push_frame(1, 0, 8'h00);
        push_frame(2, 2, 8'h60);
        wait_eof(e0 + 2, 300);
        tick(3);
        chk("t4_grants", ngnt - g0, 3);
        for (int k = 0; k < 3; k++) chk("t4_order", gnt_q[g0+k], ord_z[k]);
        chk("t4_zero_len", nzl - z0, 1);
        chk("t4_zl_timing", zl_cyc - gnt_cyc[g0+1], 2);
        chk("t4_q1_unread", drd_cnt[1] - d1, 0);
        chk("t4_nbytes", ncap - c0, 3);
        chk("t4_len1", {19'd0, cap_sof[c0], cap_eof[c0], cap_port[c0], cap_data[c0]},
            {19'd0, 1'b1, 1'b1, 3'd0, 8'h55});
        chk("t4_q2_first", {19'd0, cap_sof[c0+1], cap_eof[c0+1], cap_port[c0+1], cap_data[c0+1]},
            {19'd0, 1'b1, 1'b0, 3'd2, 8'h60});
        chk("t4_q2_last", {19'd0, cap_sof[c0+2], cap_eof[c0+2], cap_port[c0+2], cap_data[c0+2]},
            {19'd0, 1'b0, 1'b1, 3'd2, 8'h61});

        // Mask: queue 2 disabled
        do_reset();
        q_en = 4'b1011;
        snap();
        for (int q = 0; q < NUM_Q; q++) push_frame(q, 2, 8'(8'h80 + q * 16));
        wait_eof(e0 + 3, 300);
        tick(30);
        chk("t5_grants", ngnt - g0, 3);
        for (int k = 0; k < 3; k++) chk("t5_order", gnt_q[g0+k], ord_m[k]);
        chk("t5_q2_unread", drd_cnt[2] - d2, 0);
        chk("t5_q2_pending", {31'd0, ptr_fifo_empty[2]}, 0);
        chk("t5_nbytes", ncap - c0, 6);
        chk("t5_ifg_a", cap_cyc[c0+2] - cap_cyc[c0+1], 18);
        chk("t5_ifg_b", cap_cyc[c0+4] - cap_cyc[c0+3], 18);
        chk("t5_q3_byte", {21'd0, cap_port[c0+4], cap_data[c0+4]}, {21'd0, 3'd3, 8'hB0});

        // Reset mid-frame; last_q left at 0 beforehand
        do_reset();
        snap();
        push_frame(0, 2, 8'h10);
        wait_eof(e0 + 1, 100);
        tick(20);
        snap();
        push_frame(0, 100, 8'h00);
        n = 0;
        while (drd_cnt[0] - d0 < 10 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t6_in_data", {28'd0, data_fifo_rd}, 32'b0001);
        rstn = 1'b0;
        #1;
        chk("t6_rst_ctl", {27'd0, out_sof, out_eof, out_dv, busy, zero_len}, 32'd0);
        chk("t6_rst_data", {24'd0, out_data}, 32'd0);
        chk("t6_rst_rd", {24'd0, ptr_fifo_rd, data_fifo_rd}, 32'd0);
        for (int i = 0; i < NUM_Q; i++) begin
            pwr[i] = 0;
            dwr[i] = 0;
        end
        tick(2);
        rstn = 1'b1;
        snap();
        push_frame(1, 2, 8'h20);
        push_frame(0, 2, 8'h30);
        wait_eof(e0 + 2, 200);
        chk("t6_grants", ngnt - g0, 2);
        chk("t6_first_q", gnt_q[g0], 0);
        chk("t6_second_q", gnt_q[g0+1], 1);
        chk("t6_first_byte", {24'd0, cap_data[c0]}, 32'h30);

        chk("rd_onehot", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
